// File: rtl/seq_divider_iter.sv
// Iterative restoring unsigned divider: Q = A / B, R = A % B, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: a start with B != 0 and A < B completes straight from IDLE.
module seq_divider_iter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [1:0]    S_IDLE   = 2'd0;
   localparam logic [1:0]    S_RUN    = 2'd1;
   localparam logic [1:0]    S_DONE   = 2'd2;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  dvd_q, dvd_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  res_q, res_d;
   logic          dbz_q, dbz_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [W:0]    rem_sh_s;
   logic [W:0]    rem_sub_s;
   logic [W:0]    dvd_sh_s;
   logic          q_bit_s;
   logic [W-1:0]  rem_nxt_s;
   logic          early_s;

   // Dividend register doubles as the quotient shift register: its MSB leaves as a quotient bit enters.
   assign rem_sh_s  = {rem_q, dvd_q[W-1]};
   assign rem_sub_s = rem_sh_s - {1'b0, dvs_q};
   assign q_bit_s   = (rem_sh_s >= {1'b0, dvs_q});
   assign rem_nxt_s = q_bit_s ? rem_sub_s[W-1:0] : rem_sh_s[W-1:0];
   assign dvd_sh_s  = {dvd_q, q_bit_s};

`ifdef DIV_EARLY_OUT_EN
   assign early_s = (A < B);
`else
   assign early_s = 1'b0;
`endif

   // Next-state logic; Q/R/div_by_zero change only on a completion edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      res_d   = res_q;
      dbz_d   = dbz_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               dvd_d = A;
               dvs_d = B;
               rem_d = {W{1'b0}};
               cnt_d = CNT_LAST;
               if (B == {W{1'b0}}) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  quo_d   = {W{1'b1}};
                  res_d   = A;
                  dbz_d   = 1'b1;
               end else if (early_s) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  quo_d   = {W{1'b0}};
                  res_d   = A;
                  dbz_d   = 1'b0;
               end else begin
                  state_d = S_RUN;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            dvd_d = dvd_sh_s[W-1:0];
            rem_d = rem_nxt_s;
            if (cnt_q == CNT_ZERO) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               quo_d   = dvd_sh_s[W-1:0];
               res_d   = rem_nxt_s;
               dbz_d   = 1'b0;
            end else begin
               cnt_d  = cnt_q - CNT_ONE;
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
         dvd_q   <= {W{1'b0}};
         dvs_q   <= {W{1'b0}};
         rem_q   <= {W{1'b0}};
         quo_q   <= {W{1'b0}};
         res_q   <= {W{1'b0}};
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Q           = quo_q;
   assign R           = res_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_iter.sv
// Bench for seq_divider_iter at W=2 and W=4: per-cycle arithmetic model plus literal result checks.
module tb_seq_divider_iter;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       rst2_n, start2, busy2, done2, dbz2;
   logic [1:0] a2, b2, q2, r2;
   logic       rst4_n, start4, busy4, done4, dbz4;
   logic [3:0] a4, b4, q4, r4;

   seq_divider_iter #(.W(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .start(start2), .A(a2), .B(b2),
      .Q(q2), .R(r2), .busy(busy2), .done(done2), .div_by_zero(dbz2)
   );

   seq_divider_iter #(.W(4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .start(start4), .A(a4), .B(b4),
      .Q(q4), .R(r4), .busy(busy4), .done(done4), .div_by_zero(dbz4)
   );

   // Model state per DUT (index 0: W=2, index 1: W=4)
   bit m_pv [2];
   bit m_fast [2];
   bit m_pdone [2];
   int m_age [2];
   int m_rq [2];
   int m_rr [2];
   bit m_rdz [2];
   int m_lq [2];
   int m_lr [2];
   bit m_ldz [2];

   function automatic int wd(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   task automatic chk(input string nm, input int d, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s (W=%0d) t=%0t: got %0d, expected %0d", nm, wd(d), $time, act, expv);
      end
   endtask

   // One cycle of the reference: result by plain division, timing by operation age.
   task automatic model_step(input int d, input bit rs_edge, input bit rs_now, input bit st,
                             input int a, input int b, input bit dn, input bit bs,
                             input int q, input int r, input bit dz);
      int  mask;
      bit  e_done;
      bit  e_busy;
      mask   = (1 << wd(d)) - 1;
      e_done = 1'b0;
      e_busy = 1'b0;
      if (!rs_edge || !rs_now) begin
         m_pv[d]    = 1'b0;
         m_pdone[d] = 1'b0;
         m_lq[d]    = 0;
         m_lr[d]    = 0;
         m_ldz[d]   = 1'b0;
      end else begin
         if (m_pv[d]) m_age[d]++;
         if (m_pv[d] && m_pdone[d]) m_pv[d] = 1'b0;
         if (!m_pv[d] && st) begin
            m_pv[d]  = 1'b1;
            m_age[d] = 0;
            if (b == 0) begin
               m_rq[d] = mask; m_rr[d] = a; m_rdz[d] = 1'b1; m_fast[d] = 1'b1;
            end else begin
               m_rq[d] = a / b; m_rr[d] = a % b; m_rdz[d] = 1'b0; m_fast[d] = EARLY && (a < b);
            end
         end
         if (m_pv[d]) begin
            e_done = m_fast[d] ? (m_age[d] == 0) : (m_age[d] == wd(d));
            e_busy = !m_fast[d] && (m_age[d] < wd(d));
         end
         if (e_done) begin
            m_lq[d] = m_rq[d]; m_lr[d] = m_rr[d]; m_ldz[d] = m_rdz[d];
         end
         m_pdone[d] = e_done;
      end
      chk("done", d, int'(dn), int'(e_done));
      chk("busy", d, int'(bs), int'(e_busy));
      chk("Q", d, q, m_lq[d]);
      chk("R", d, r, m_lr[d]);
      chk("div_by_zero", d, int'(dz), int'(m_ldz[d]));
   endtask

   // Compare process for the W=2 instance
   initial begin
      bit s_rst, s_st;
      int s_a, s_b;
      forever begin
         @(posedge clk);
         s_rst = rst2_n; s_st = start2; s_a = int'(a2); s_b = int'(b2);
         @(negedge clk);
         model_step(0, s_rst, rst2_n, s_st, s_a, s_b, done2, busy2, int'(q2), int'(r2), dbz2);
      end
   end

   // Compare process for the W=4 instance
   initial begin
      bit s_rst, s_st;
      int s_a, s_b;
      forever begin
         @(posedge clk);
         s_rst = rst4_n; s_st = start4; s_a = int'(a4); s_b = int'(b4);
         @(negedge clk);
         model_step(1, s_rst, rst4_n, s_st, s_a, s_b, done4, busy4, int'(q4), int'(r4), dbz4);
      end
   end

   function automatic bit cur_done(input int d);
      return (d == 0) ? done2 : done4;
   endfunction
   function automatic int cur_q(input int d);
      return (d == 0) ? int'(q2) : int'(q4);
   endfunction
   function automatic int cur_r(input int d);
      return (d == 0) ? int'(r2) : int'(r4);
   endfunction
   function automatic bit cur_dz(input int d);
      return (d == 0) ? dbz2 : dbz4;
   endfunction

   task automatic drive(input int d, input bit st, input int a, input int b);
      if (d == 0) begin
         start2 = st; a2 = 2'(a); b2 = 2'(b);
      end else begin
         start4 = st; a4 = 4'(a); b4 = 4'(b);
      end
   endtask

   task automatic wait_done(input int d);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (cur_done(d)) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #2;
      end
      chk("done within budget", d, int'(seen), 1);
   endtask

   // Pulse start (in the current cycle if b2b), scramble operands after capture, wait for done.
   task automatic op(input int d, input int a, input int b, input bit b2b);
      if (!b2b) begin
         @(posedge clk); #2;
      end
      drive(d, 1'b1, a, b);
      @(posedge clk); #2;
      drive(d, 1'b0, int'($urandom), int'($urandom));
      wait_done(d);
   endtask

   task automatic exp_res(input int d, input int eq, input int er, input bit ez);
      chk("Q literal", d, cur_q(d), eq);
      chk("R literal", d, cur_r(d), er);
      chk("div_by_zero literal", d, int'(cur_dz(d)), int'(ez));
   endtask

   task automatic inv(input int d, input int a, input int b);
      if (b != 0) begin
         chk("Q*B+R==A", d, cur_q(d) * b + cur_r(d), a);
         chk("R<B", d, int'(cur_r(d) < b), 1);
      end else begin
         chk("B=0 flag", d, int'(cur_dz(d)), 1);
      end
   endtask

   initial begin
      rst2_n = 1'b0;
      rst4_n = 1'b0;
      drive(0, 1'b0, 0, 0);
      drive(1, 1'b0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      chk("reset Q", 0, int'(q2), 0);
      chk("reset R", 0, int'(r2), 0);
      chk("reset busy", 0, int'(busy2), 0);
      chk("reset done", 0, int'(done2), 0);
      chk("reset div_by_zero", 0, int'(dbz2), 0);
      rst2_n = 1'b1;
      rst4_n = 1'b1;

      op(0, 3, 1, 1'b0); exp_res(0, 3, 0, 1'b0);
      op(0, 3, 2, 1'b0); exp_res(0, 1, 1, 1'b0);
      op(0, 2, 3, 1'b0); exp_res(0, 0, 2, 1'b0);
      op(0, 2, 0, 1'b0); exp_res(0, 3, 2, 1'b1);
      op(0, 2, 1, 1'b0); exp_res(0, 2, 0, 1'b0);

      // start held through RUN with new operands: must be ignored
      @(posedge clk); #2;
      drive(0, 1'b1, 3, 1);
      @(posedge clk); #2;
      drive(0, 1'b1, 1, 2);
      @(posedge clk); #2;
      drive(0, 1'b0, 0, 0);
      wait_done(0);
      exp_res(0, 3, 0, 1'b0);

      // back-to-back: new start issued during the DONE cycle
      op(0, 3, 2, 1'b0); exp_res(0, 1, 1, 1'b0);
      op(0, 2, 1, 1'b1); exp_res(0, 2, 0, 1'b0);
      op(0, 1, 0, 1'b1); exp_res(0, 3, 1, 1'b1);

      // reset one cycle after capture
      @(posedge clk); #2;
      drive(0, 1'b1, 3, 1);
      @(posedge clk); #2;
      drive(0, 1'b0, 2, 2);
      @(posedge clk); #2;
      rst2_n = 1'b0;
      #1;
      chk("mid-op reset Q", 0, int'(q2), 0);
      chk("mid-op reset R", 0, int'(r2), 0);
      chk("mid-op reset busy", 0, int'(busy2), 0);
      chk("mid-op reset done", 0, int'(done2), 0);
      chk("mid-op reset div_by_zero", 0, int'(dbz2), 0);
      @(posedge clk); #2;
      rst2_n = 1'b1;
      op(0, 3, 2, 1'b0); exp_res(0, 1, 1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         int ra, rb;
         ra = int'($urandom_range(0, 3));
         rb = int'($urandom_range(0, 3));
         op(0, ra, rb, 1'($urandom_range(0, 1)));
         inv(0, ra, rb);
      end

      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            op(0, a, b, 1'b0);
            inv(0, a, b);
         end
      end

      op(1, 15, 1, 1'b0); exp_res(1, 15, 0, 1'b0);
      op(1, 9, 4, 1'b0);  exp_res(1, 2, 1, 1'b0);
      op(1, 7, 0, 1'b1);  exp_res(1, 15, 7, 1'b1);
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            op(1, a, b, 1'((a + b) % 2));
            inv(1, a, b);
         end
      end

      repeat (4) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
